instr_queue: RTL and testbench
==============================

Name: instr_queue

Overview:
- Circular FIFO between the Fetch→Issue pipeline register and dispatch/rename.
- Buffers fetched instructions (PC and instruction word) and presents the oldest entry to dispatch through a valid/ready handshake.
- Drives queue_full back to fetch. The threshold leaves one slot free, because the upstream register always delivers one more instruction after the stall asserts.
- Supports a one-cycle flush for branch mispredicts.

Parameters:
- DEPTH, 8: number of entries. Must be a power of 2 and at least 4.
- PC_W, 32: PC width.
- INSTR_W, 32: instruction word width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears queue state on the clk edge where it is high
- flush  input  1  discard all entries (mispredict); synchronous
- in_valid  input  1  pipeline register holds a valid instruction this cycle
- in_pc  input  PC_W  PC of incoming instruction
- in_instr  input  INSTR_W  incoming instruction word
- queue_full  output  1  stall request to fetch and to the pipeline register
- out_valid  output  1  head entry valid
- out_ready  input  1  dispatch accepts head this cycle
- out_pc  output  PC_W  head PC
- out_instr  output  INSTR_W  head instruction word
- count  output  $clog2(DEPTH)+1  number of occupied entries
- overflow  output  1  sticky error: a push was dropped

Behaviour:
- Storage and pointers:
  - DEPTH-entry array with head and tail pointers, each $clog2(DEPTH) bits, plus a count register.
  - Pointers wrap from DEPTH-1 to 0 by natural overflow.
- Handshake signals:
  - pop = out_valid && out_ready.
  - push = in_valid && (count < DEPTH || pop).
  - A pop frees its slot in the same cycle, so a push is accepted when full and popping.
- Each edge, when neither reset nor flush is high:
  - push: write in_pc/in_instr at tail; tail += 1.
  - pop: head += 1.
  - count += push - pop, so simultaneous push and pop leaves count unchanged.
- Dropped push: if in_valid && count == DEPTH && !pop, the instruction is dropped and overflow is set to 1. overflow stays 1 until reset; flush does not clear it.
- Output timing:
  - First-word fall-through with zero latency: out_pc/out_instr come combinationally from the head entry.
  - out_valid = (count != 0).
  - When count == 0, out_pc/out_instr are driven to 0.
  - An instruction pushed at edge t is visible at the output in the cycle after t, giving one cycle of write-to-read latency.
- queue_full:
  - Combinational: queue_full = (count >= DEPTH-1).
  - The one reserved slot absorbs the instruction already in flight in the pipeline register.
- flush (higher priority than push/pop):
  - On an edge with flush = 1: head = tail = count = 0.
  - A push in the same cycle is discarded and does not set overflow.
  - A pop in the same cycle has no effect. out_valid may be 1 during the flush cycle, but dispatch must ignore the handshake when flush is high.
- reset (highest priority, overrides flush/push/pop):
  - head = tail = count = 0 and overflow = 0.
  - Storage array contents are don't-care.
  - Resulting outputs: out_valid = 0, out_pc = 0, out_instr = 0, queue_full = 0, count = 0, overflow = 0.
  - Reset asserted mid-stream empties the queue on that edge.
- Ordering: entries leave strictly in push order across pointer wrap-around.

Test Plan:
1. Reset, then push 3 instructions (pc 0x100/0x104/0x108, out_ready=0) → count=3, out_valid=1, out_pc=0x100, queue_full=0.
2. Push until count=7 (DEPTH=8) → queue_full=1 at count=7. Push the 8th in-flight instruction → count=8, overflow=0. Push a 9th with no pop → dropped, overflow=1, count stays 8.
3. Full queue (count=8), in_valid=1 and out_ready=1 on the same cycle → head advances, new entry written, count stays 8, overflow stays 0.
4. Wrap-around: push 6, pop 6, push 6 more (pc 0x200+4i), then drain → the second batch is returned in order 0x200…0x214 across the pointer wrap, out_valid=0 after the last pop.
5. Flush with count=5 and in_valid=1 → next cycle count=0, out_valid=0, out_pc=0, queue_full=0, overflow unchanged. A push on the following cycle lands at entry 0 and is output correctly.
6. Reset asserted with count=4 and overflow=1 while pushing and popping → next cycle every output is 0. Pushes after reset deassertion behave as in scenario 1.

Source files
------------

// File: rtl/instr_queue.sv
// instr_queue: circular fetch-to-dispatch FIFO with fall-through head, early-full stall and sticky overflow
module instr_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W = 32,
  parameter int INSTR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INSTR_W-1:0]       in_instr,
  output logic                     queue_full,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] full_n = CW'(DEPTH);
  localparam logic [AW:0] thr_n = CW'(DEPTH - 1);
  logic [PC_W-1:0] pc_mem [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0] cnt;
  logic push, pop;
  always_comb begin
    out_valid = cnt != '0;
    pop = out_valid && out_ready;
    push = in_valid && (cnt != full_n || pop);
    out_pc = out_valid ? pc_mem[head] : '0;
    out_instr = out_valid ? instr_mem[head] : '0;
    queue_full = cnt >= thr_n;
    count = cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
      if (in_valid && cnt == full_n && !pop) overflow <= 1'b1;
    end
  end
  // storage is not reset; only pointers define what is valid
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) begin
      pc_mem[tail] <= in_pc;
      instr_mem[tail] <= in_instr;
    end
  end
endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed scenario tasks for instr_queue
module tb_instr_queue;
  logic clk = 1'b0;
  logic reset = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_pc = '0, in_instr = '0;
  logic queue_full, out_valid, overflow;
  logic [31:0] out_pc, out_instr;
  logic [3:0] count;
  int n_checks = 0, n_fail = 0;
  instr_queue dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .queue_full(queue_full), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .count(count),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic push_one(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc = pc;
    in_instr = ~pc;
    cyc();
    in_valid = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({out_valid, out_pc, out_instr, queue_full, count, overflow} !== 71'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b pc=%h in=%h full=%b cnt=%0d ovf=%b exp all 0",
               out_valid, out_pc, out_instr, queue_full, count, overflow);
    end
  endtask
  task automatic test_push3();
    for (int i = 0; i < 3; i++) push_one(32'h100 + 32'(4 * i));
    n_checks++;
    if ({count, out_valid, queue_full, overflow} !== {4'd3, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL push3_status got cnt=%0d v=%b full=%b ovf=%b exp 3 1 0 0", count, out_valid, queue_full, overflow);
    end
    n_checks++;
    if ({out_pc, out_instr} !== {32'h100, ~32'h100}) begin
      n_fail++;
      $display("FAIL push3_head got pc=%h in=%h exp 100 %h", out_pc, out_instr, ~32'h100);
    end
  endtask
  task automatic test_full();
    for (int i = 3; i < 6; i++) push_one(32'h100 + 32'(4 * i));
    n_checks++;
    if ({count, queue_full} !== {4'd6, 1'b0}) begin
      n_fail++;
      $display("FAIL full_at6 got cnt=%0d full=%b exp 6 0", count, queue_full);
    end
    push_one(32'h118);
    n_checks++;
    if ({count, queue_full} !== {4'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL full_at7 got cnt=%0d full=%b exp 7 1", count, queue_full);
    end
    push_one(32'h11c);
    n_checks++;
    if ({count, queue_full, overflow} !== {4'd8, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL full_at8 got cnt=%0d full=%b ovf=%b exp 8 1 0", count, queue_full, overflow);
    end
    push_one(32'h120);
    n_checks++;
    if ({count, overflow, out_pc} !== {4'd8, 1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL drop_push got cnt=%0d ovf=%b pc=%h exp 8 1 100", count, overflow, out_pc);
    end
  endtask
  task automatic test_flush();
    out_ready = 1'b1;
    repeat (3) cyc();
    out_ready = 1'b0;
    n_checks++;
    if ({count, out_pc} !== {4'd5, 32'h10c}) begin
      n_fail++;
      $display("FAIL pre_flush got cnt=%0d pc=%h exp 5 10c", count, out_pc);
    end
    flush = 1'b1;
    in_valid = 1'b1;
    in_pc = 32'h999;
    in_instr = ~32'h999;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if ({count, out_valid, out_pc, queue_full, overflow} !== {4'd0, 1'b0, 32'h0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_state got cnt=%0d v=%b pc=%h full=%b ovf=%b exp 0 0 0 0 1",
               count, out_valid, out_pc, queue_full, overflow);
    end
    push_one(32'h400);
    n_checks++;
    if ({count, out_valid, out_pc, out_instr} !== {4'd1, 1'b1, 32'h400, ~32'h400}) begin
      n_fail++;
      $display("FAIL post_flush_push got cnt=%0d v=%b pc=%h in=%h exp 1 1 400 %h",
               count, out_valid, out_pc, out_instr, ~32'h400);
    end
  endtask
  task automatic test_reset_mid();
    for (int i = 1; i < 4; i++) push_one(32'h400 + 32'(4 * i));
    n_checks++;
    if ({count, overflow} !== {4'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL pre_reset got cnt=%0d ovf=%b exp 4 1", count, overflow);
    end
    reset = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_pc = 32'h500;
    in_instr = ~32'h500;
    cyc();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, out_pc, out_instr, queue_full, count, overflow} !== 71'd0) begin
      n_fail++;
      $display("FAIL mid_reset got v=%b pc=%h in=%h full=%b cnt=%0d ovf=%b exp all 0",
               out_valid, out_pc, out_instr, queue_full, count, overflow);
    end
    test_push3();
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 8; i++) push_one(32'h300 + 32'(4 * i));
    in_valid = 1'b1;
    in_pc = 32'h320;
    in_instr = ~32'h320;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    n_checks++;
    if ({count, overflow, out_pc} !== {4'd8, 1'b0, 32'h304}) begin
      n_fail++;
      $display("FAIL full_push_pop got cnt=%0d ovf=%b pc=%h exp 8 0 304", count, overflow, out_pc);
    end
    for (int i = 1; i < 9; i++) begin
      n_checks++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h300 + 32'(4 * i), ~(32'h300 + 32'(4 * i))}) begin
        n_fail++;
        $display("FAIL b2b_drain%0d got v=%b pc=%h exp 1 %h", i, out_valid, out_pc, 32'h300 + 32'(4 * i));
      end
      cyc();
    end
    out_ready = 1'b0;
    n_checks++;
    if ({count, out_valid} !== {4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_empty got cnt=%0d v=%b exp 0 0", count, out_valid);
    end
  endtask
  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 6; i++) push_one(32'h180 + 32'(4 * i));
    out_ready = 1'b1;
    repeat (6) cyc();
    out_ready = 1'b0;
    n_checks++;
    if ({count, out_valid} !== {4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_first_drain got cnt=%0d v=%b exp 0 0", count, out_valid);
    end
    for (int i = 0; i < 6; i++) push_one(32'h200 + 32'(4 * i));
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h200 + 32'(4 * i), ~(32'h200 + 32'(4 * i))}) begin
        n_fail++;
        $display("FAIL wrap_order%0d got v=%b pc=%h exp 1 %h", i, out_valid, out_pc, 32'h200 + 32'(4 * i));
      end
      cyc();
    end
    out_ready = 1'b0;
    n_checks++;
    if ({count, out_valid, out_pc} !== {4'd0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL wrap_empty got cnt=%0d v=%b pc=%h exp 0 0 0", count, out_valid, out_pc);
    end
  endtask
  initial begin
    #1;
    test_reset();
    test_push3();
    test_full();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
